pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the RV32I fetch stage, successor to the basic PC register. It holds the fetch PC and selects the next PC each cycle from trap vector, branch/jump redirect, a redirect captured during a stall, a return-address-stack prediction, or sequential increment. Redirects that arrive while fetch is stalled are held rather than lost. It sits between the execute/CSR redirect logic and the instruction memory address port.

## Interface
- WIDTH, 32: address width.
- RESET_VECTOR, 0: PC value after reset.
- INC, 4: sequential increment.
- RAS_DEPTH, 4: return-address-stack entries; power of two, ≥2.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- nEN  in  1  active-low advance enable; 1 = stall and PC holds.
- TRAP_VALID  in  1  trap/exception taken this cycle.
- TRAP_VECTOR  in  WIDTH  trap target.
- REDIRECT_VALID  in  1  branch/jump resolved to a non-sequential target.
- REDIRECT_PC  in  WIDTH  redirect target.
- CALL  in  1  instruction at PC predecoded as a call.
- RET  in  1  instruction at PC predecoded as a return.
- PC  out  WIDTH  current fetch address (registered).
- PC_PLUS  out  WIDTH  PC + INC (combinational).
- MISALIGNED  out  1  PC[1:0] != 0 (combinational).
- PENDING  out  1  a held redirect or trap is waiting (registered).
- RAS_EMPTY  out  1  RAS holds no entries (registered).

## Operation
- Reset (RST=1 at edge): PC=RESET_VECTOR, pending cleared (kind NONE), RAS count=0, RAS pointer=0. PENDING=0, RAS_EMPTY=1. RST overrides every other input.
- Advance cycle (nEN=0), next PC by strict priority:
  1. TRAP_VALID → TRAP_VECTOR.
  2. pending kind TRAP → held target.
  3. REDIRECT_VALID → REDIRECT_PC.
  4. pending kind REDIRECT → held target.
  5. RET and RAS non-empty → popped top.
  6. otherwise → PC+INC.
  Pending is cleared on every advance cycle.
- Stall cycle (nEN=1): PC holds. Capture rules:
  - TRAP_VALID: pending = (TRAP, TRAP_VECTOR), overwriting any pending entry.
  - REDIRECT_VALID without TRAP_VALID: pending = (REDIRECT, REDIRECT_PC) unless pending kind is TRAP, which is kept.
  - CALL/RET ignored.
- RAS, updated only on advance cycles where priorities 1–4 are all inactive (the fetched instruction is not squashed):
  - CALL only: push PC+INC.
  - RET only, non-empty: pop.
  - RET only, empty: ignored; next PC = PC+INC.
  - CALL and RET together: top entry replaced by PC+INC, next PC = old top. If empty, plain push.
  - Push when full: overwrite oldest entry (circular pointer wraps), count saturates at RAS_DEPTH.
- Arithmetic is modulo 2^WIDTH; PC+INC wraps silently at the top of the address space.
- MISALIGNED is reported only. The unit never alters PC because of it.

## Timing
- PC, PENDING and RAS_EMPTY are registered. Selected next PC appears one cycle after the advance edge.
- Redirect or trap on an advance cycle: target on PC the next cycle (1-cycle latency).
- Redirect captured during a stall: PENDING=1 the following cycle. Target appears on PC one cycle after nEN returns to 0.
- RET prediction: popped value on PC one cycle after the advance edge.
- PC_PLUS and MISALIGNED follow PC combinationally in the same cycle.
- RST asserted mid-stall with pending set: pending discarded, PC=RESET_VECTOR next cycle.

## Structure
- Package pc_pkg holds:
  - pend_kind_t enum {PEND_NONE, PEND_REDIRECT, PEND_TRAP}.
  - Default INC constant.
  - RAS pointer width as $clog2(RAS_DEPTH).
- Sub-module pc_ras handles:
  - Circular stack storage, pointer and count.
  - push/pop/replace controls, top and empty outputs.
  - Synchronous active-high reset on CLK/RST.
- Next-PC priority mux and pending register live in pc_unit.

## Test plan
- Reset with RESET_VECTOR=0x100; release, nEN=0 for 3 cycles → PC 0x100, 0x104, 0x108, 0x10C; RAS_EMPTY=1.
- nEN=1 at PC=0x200 with REDIRECT_VALID pulse to 0x400 → PC stays 0x200, PENDING=1. After nEN=0 → PC=0x400, PENDING=0.
- Stall: redirect to 0x500, then trap to 0x80, then redirect to 0x600 → on release PC=0x80. Same-cycle TRAP_VALID and REDIRECT_VALID while advancing → PC=TRAP_VECTOR.
- CALL at 0x10 (advance to 0x14), later RET at 0x300 → next PC=0x14, RAS_EMPTY=1. RET with empty RAS at 0x40 → PC=0x44.
- RAS_DEPTH=4: five CALLs at 0x0, 0x10, 0x20, 0x30, 0x40, then five RETs → 0x44, 0x34, 0x24, 0x14, then sequential (oldest entry 0x4 overwritten).
- CALL with simultaneous REDIRECT_VALID → RAS unchanged. RST during PENDING=1 → PC=RESET_VECTOR, PENDING=0.

Source files
------------

// File: rtl/pc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_pkg : shared types and defaults for the fetch program counter   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pc_pkg;

   typedef enum logic [1:0] {
      PEND_NONE     = 2'd0,
      PEND_REDIRECT = 2'd1,
      PEND_TRAP     = 2'd2
   } pend_kind_t;

   localparam int C_INC_DEFAULT = 4;
   localparam int C_RAS_DEPTH   = 4;
   localparam int C_RAS_PTR_W   = $clog2(C_RAS_DEPTH);

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_ras : circular return-address stack, oldest entry overwritten   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_ras
   import pc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = C_RAS_DEPTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PUSH,
   input  logic             POP,
   input  logic             REPLACE,
   input  logic [WIDTH-1:0] DATA,
   output logic [WIDTH-1:0] TOP,
   output logic             EMPTY
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] w_top_idx;

   // r_ptr names the next free slot; when full that slot is the oldest entry
   assign w_top_idx = r_ptr - PTR_W'(1);
   assign TOP       = r_mem[w_top_idx];
   assign EMPTY     = (r_count == '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ptr   <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (PUSH) begin
         r_mem[r_ptr] <= DATA;
         r_ptr        <= r_ptr + PTR_W'(1);
         if (r_count != c_full) begin
            r_count <= r_count + CNT_W'(1);
         end
      end else if (POP) begin
         r_ptr   <= w_top_idx;
         r_count <= r_count - CNT_W'(1);
      end else if (REPLACE) begin
         r_mem[w_top_idx] <= DATA;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_unit : fetch PC with trap/redirect priority, stall-held redirect|
// |           capture and return-address-stack prediction. Rev 1.0     |
// +--------------------------------------------------------------------+
module pc_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               INC          = C_INC_DEFAULT,
   parameter int               RAS_DEPTH    = C_RAS_DEPTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             nEN,
   input  logic             TRAP_VALID,
   input  logic [WIDTH-1:0] TRAP_VECTOR,
   input  logic             REDIRECT_VALID,
   input  logic [WIDTH-1:0] REDIRECT_PC,
   input  logic             CALL,
   input  logic             RET,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC_PLUS,
   output logic             MISALIGNED,
   output logic             PENDING,
   output logic             RAS_EMPTY
);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_pend_pc;
   pend_kind_t       r_pend_kind;

   logic [WIDTH-1:0] w_pc_plus;
   logic [WIDTH-1:0] w_next_pc;
   logic [WIDTH-1:0] w_ras_top;
   logic             w_ras_empty;
   logic             w_seq_ok;
   logic             w_push;
   logic             w_pop;
   logic             w_replace;

   assign w_pc_plus  = r_pc + WIDTH'(INC);
   assign PC         = r_pc;
   assign PC_PLUS    = w_pc_plus;
   assign MISALIGNED = |r_pc[1:0];
   assign PENDING    = (r_pend_kind != PEND_NONE);
   assign RAS_EMPTY  = w_ras_empty;

   // The fetched instruction survives only when nothing above RET in priority fires
   assign w_seq_ok  = !nEN && !TRAP_VALID && !REDIRECT_VALID && (r_pend_kind == PEND_NONE);
   assign w_push    = w_seq_ok && CALL && (!RET || w_ras_empty);
   assign w_replace = w_seq_ok && CALL && RET && !w_ras_empty;
   assign w_pop     = w_seq_ok && RET && !CALL && !w_ras_empty;

   always_comb begin
      w_next_pc = w_pc_plus;
      if (TRAP_VALID) begin
         w_next_pc = TRAP_VECTOR;
      end else if (r_pend_kind == PEND_TRAP) begin
         w_next_pc = r_pend_pc;
      end else if (REDIRECT_VALID) begin
         w_next_pc = REDIRECT_PC;
      end else if (r_pend_kind == PEND_REDIRECT) begin
         w_next_pc = r_pend_pc;
      end else if (RET && !w_ras_empty) begin
         w_next_pc = w_ras_top;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc        <= RESET_VECTOR;
         r_pend_kind <= PEND_NONE;
         r_pend_pc   <= '0;
      end else if (!nEN) begin
         r_pc        <= w_next_pc;
         r_pend_kind <= PEND_NONE;
      end else if (TRAP_VALID) begin
         r_pend_kind <= PEND_TRAP;
         r_pend_pc   <= TRAP_VECTOR;
      end else if (REDIRECT_VALID && (r_pend_kind != PEND_TRAP)) begin
         r_pend_kind <= PEND_REDIRECT;
         r_pend_pc   <= REDIRECT_PC;
      end
   end

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .CLK     (CLK),
      .RST     (RST),
      .PUSH    (w_push),
      .POP     (w_pop),
      .REPLACE (w_replace),
      .DATA    (w_pc_plus),
      .TOP     (w_ras_top),
      .EMPTY   (w_ras_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_unit : directed-vector bench for pc_unit. Rev 1.0            |
// +--------------------------------------------------------------------+
module tb_pc_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        nEN = 1'b0;
   logic        TRAP_VALID = 1'b0;
   logic [31:0] TRAP_VECTOR = '0;
   logic        REDIRECT_VALID = 1'b0;
   logic [31:0] REDIRECT_PC = '0;
   logic        CALL = 1'b0;
   logic        RET = 1'b0;
   logic [31:0] PC;
   logic [31:0] PC_PLUS;
   logic        MISALIGNED;
   logic        PENDING;
   logic        RAS_EMPTY;

   int n_checks = 0;
   int n_fail   = 0;

   pc_unit #(
      .WIDTH        (32),
      .RESET_VECTOR (32'h100),
      .INC          (4),
      .RAS_DEPTH    (4)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .nEN            (nEN),
      .TRAP_VALID     (TRAP_VALID),
      .TRAP_VECTOR    (TRAP_VECTOR),
      .REDIRECT_VALID (REDIRECT_VALID),
      .REDIRECT_PC    (REDIRECT_PC),
      .CALL           (CALL),
      .RET            (RET),
      .PC             (PC),
      .PC_PLUS        (PC_PLUS),
      .MISALIGNED     (MISALIGNED),
      .PENDING        (PENDING),
      .RAS_EMPTY      (RAS_EMPTY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs set before step are taken at the next rising edge; outputs sampled 1 ns later
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_ctl();
      TRAP_VALID     = 1'b0;
      REDIRECT_VALID = 1'b0;
      CALL           = 1'b0;
      RET            = 1'b0;
   endtask

   task automatic jump(input logic [31:0] target);
      REDIRECT_VALID = 1'b1;
      REDIRECT_PC    = target;
      step();
      REDIRECT_VALID = 1'b0;
   endtask

   initial begin
      logic [31:0] ret_exp [4];
      ret_exp[0] = 32'h44; ret_exp[1] = 32'h34; ret_exp[2] = 32'h24; ret_exp[3] = 32'h14;

      #2;
      RST = 1'b1;
      step();
      check("reset_pc", PC, 32'h100);
      check("reset_pending", {31'd0, PENDING}, 32'd0);
      check("reset_ras_empty", {31'd0, RAS_EMPTY}, 32'd1);
      check("reset_pc_plus", PC_PLUS, 32'h104);
      RST = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         check("seq_pc", PC, 32'h100 + 32'(4 * i));
      end
      check("seq_ras_empty", {31'd0, RAS_EMPTY}, 32'd1);

      // Redirect captured while stalled
      jump(32'h200);
      check("redir_pc", PC, 32'h200);
      nEN = 1'b1;
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h400;
      step();
      clear_ctl();
      check("stall_hold_pc", PC, 32'h200);
      check("stall_pending", {31'd0, PENDING}, 32'd1);
      step();
      check("stall_hold_pc2", PC, 32'h200);
      nEN = 1'b0;
      step();
      check("pend_redir_pc", PC, 32'h400);
      check("pend_cleared", {31'd0, PENDING}, 32'd0);

      // Stalled trap beats earlier and later redirects
      nEN = 1'b1;
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h500;
      step();
      clear_ctl();
      TRAP_VALID = 1'b1; TRAP_VECTOR = 32'h80;
      step();
      clear_ctl();
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h600;
      step();
      clear_ctl();
      check("trap_stall_pc", PC, 32'h400);
      nEN = 1'b0;
      step();
      check("pend_trap_pc", PC, 32'h80);

      TRAP_VALID = 1'b1; TRAP_VECTOR = 32'h90;
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h700;
      step();
      clear_ctl();
      check("trap_over_redir", PC, 32'h90);

      // Held trap outranks a live redirect on release
      nEN = 1'b1;
      TRAP_VALID = 1'b1; TRAP_VECTOR = 32'hC0;
      step();
      clear_ctl();
      nEN = 1'b0;
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'hD00;
      step();
      clear_ctl();
      check("pend_trap_over_redir", PC, 32'hC0);

      // CALL / RET basic
      jump(32'h10);
      CALL = 1'b1;
      step();
      clear_ctl();
      check("call_pc", PC, 32'h14);
      check("call_ras_nonempty", {31'd0, RAS_EMPTY}, 32'd0);
      jump(32'h300);
      RET = 1'b1;
      step();
      clear_ctl();
      check("ret_pc", PC, 32'h14);
      check("ret_ras_empty", {31'd0, RAS_EMPTY}, 32'd1);
      jump(32'h40);
      RET = 1'b1;
      step();
      clear_ctl();
      check("ret_empty_seq", PC, 32'h44);

      // Five calls into a four-deep stack, then five returns
      for (int i = 0; i < 5; i++) begin
         jump(32'(16 * i));
         CALL = 1'b1;
         step();
         clear_ctl();
      end
      check("five_call_pc", PC, 32'h44);
      for (int i = 0; i < 4; i++) begin
         RET = 1'b1;
         step();
         check("ras_pop", PC, ret_exp[i]);
      end
      step();
      clear_ctl();
      check("ras_drained_seq", PC, 32'h18);
      check("ras_drained_empty", {31'd0, RAS_EMPTY}, 32'd1);

      // Squashed CALL leaves the stack alone
      jump(32'h780);
      CALL = 1'b1; REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h800;
      step();
      clear_ctl();
      check("squash_call_pc", PC, 32'h800);
      check("squash_call_empty", {31'd0, RAS_EMPTY}, 32'd1);
      RET = 1'b1;
      step();
      clear_ctl();
      check("squash_ret_seq", PC, 32'h804);

      // CALL and RET together replace the top
      jump(32'h900);
      CALL = 1'b1;
      step();
      clear_ctl();
      jump(32'hA00);
      CALL = 1'b1; RET = 1'b1;
      step();
      clear_ctl();
      check("callret_pc", PC, 32'h904);
      RET = 1'b1;
      step();
      clear_ctl();
      check("replaced_top", PC, 32'hA04);
      check("replaced_empty", {31'd0, RAS_EMPTY}, 32'd1);

      // CALL during stall is ignored
      nEN = 1'b1; CALL = 1'b1;
      step();
      clear_ctl();
      nEN = 1'b0;
      check("stall_call_hold", PC, 32'hA04);
      check("stall_call_empty", {31'd0, RAS_EMPTY}, 32'd1);

      // Misalignment is flagged but does not steer the PC
      jump(32'h402);
      check("misaligned_flag", {31'd0, MISALIGNED}, 32'd1);
      step();
      check("misaligned_seq", PC, 32'h406);
      jump(32'h408);
      check("aligned_flag", {31'd0, MISALIGNED}, 32'd0);

      // Wrap at top of address space
      jump(32'hFFFF_FFFC);
      check("wrap_pc_plus", PC_PLUS, 32'h0);
      step();
      check("wrap_pc", PC, 32'h0);

      // Reset discards a held redirect
      nEN = 1'b1;
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h123;
      step();
      clear_ctl();
      check("rst_pre_pending", {31'd0, PENDING}, 32'd1);
      RST = 1'b1;
      step();
      check("rst_pending_pc", PC, 32'h100);
      check("rst_pending_clear", {31'd0, PENDING}, 32'd0);
      RST = 1'b0; nEN = 1'b0;
      step();
      check("post_rst_seq", PC, 32'h104);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
